// File: rtl/core_intf_trace_rom.sv
// core_intf_trace_rom
//   Per-core trace ROM for the multicore cache bench. For one core it plays
//   back a program that writes words_p words into that core's private region,
//   reads each one back and checks the returned value, and then signals done.
//   Lookup is purely combinational (addr_i -> data_o in the same cycle), which
//   is what the trace-replay node expects.
//
//   Optional build: define TRACE_ROM_MONITOR_EN to add a sticky error_o flag.
//   It is set when the replay node indexes past the done entry. Without the
//   macro, error_o is tied low and clk_i/reset_i are unused.
//
//   Word layout: {op[3:0], payload[68:0]}
//     send    : payload = {4'b0, we, addr[31:0], wdata[31:0]}
//     receive : payload = {37'b0, rdata[31:0]}
//     done    : payload = 69'b0

module core_intf_trace_rom #(
    parameter int width_p      = 73,
    parameter int addr_width_p = 15,
    parameter int core_id_p    = 0,
    parameter int words_p      = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [addr_width_p-1:0] addr_i,
    output logic [width_p-1:0]      data_o,
    output logic                    error_o
);

    localparam logic [3:0] op_send_lp = 4'b0001;
    localparam logic [3:0] op_recv_lp = 4'b0010;
    localparam logic [3:0] op_done_lp = 4'b0011;

    // Each core owns a 512-byte window, so the cores never share addresses.
    localparam logic [31:0] base_lp       = 32'(core_id_p) * 32'h200;
    localparam logic [7:0]  core_byte_lp  = 8'(core_id_p);
    localparam logic [31:0] n_write_lp    = 32'(words_p);
    localparam logic [31:0] n_total_lp    = 32'(3 * words_p);

    // pat(i) is the data word that the program writes to, and expects back
    // from, word i of this core's region.
    function automatic logic [31:0] pat(input logic [15:0] idx);
        return {core_byte_lp, 8'hA5, idx};
    endfunction

    logic [31:0] k;
    logic [31:0] rel;
    logic [31:0] j;
    logic [72:0] word;

    assign k = 32'(addr_i);

    // Decode the entry index into the write phase, the read/check phase or done.
    always_comb begin
        rel  = k - n_write_lp;
        j    = {1'b0, rel[31:1]};
        word = {op_done_lp, 69'b0};
        if (k < n_write_lp) begin
            word = {op_send_lp, 4'b0, 1'b1, base_lp + (k << 2), pat(k[15:0])};
        end else if (k < n_total_lp) begin
            // Reads and their expected responses are interleaved: even offsets
            // issue the read, odd offsets expect the data.
            if (!rel[0]) begin
                word = {op_send_lp, 4'b0, 1'b0, base_lp + (j << 2), 32'b0};
            end else begin
                word = {op_recv_lp, 37'b0, pat(j[15:0])};
            end
        end
    end

    assign data_o = word;

`ifdef TRACE_ROM_MONITOR_EN
    logic error_q;

    // Sticky flag for any index past the done entry. Reset has priority.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else if (k > n_total_lp) begin
            error_q <= 1'b1;
        end
    end

    assign error_o = error_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ reset_i;
    assign error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_core_intf_trace_rom.sv
module tb_core_intf_trace_rom;

    localparam int N = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] addr = '0;
    logic [72:0] data_a [N];
    logic        err_a  [N];

    always #5 clk = ~clk;

    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .core_id_p(0), .words_p(16)) u_rom0 (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_o(data_a[0]), .error_o(err_a[0]));
    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .core_id_p(1), .words_p(16)) u_rom1 (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_o(data_a[1]), .error_o(err_a[1]));
    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .core_id_p(2), .words_p(16)) u_rom2 (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_o(data_a[2]), .error_o(err_a[2]));
    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .core_id_p(3), .words_p(16)) u_rom3 (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_o(data_a[3]), .error_o(err_a[3]));
    core_intf_trace_rom #(.width_p(73), .addr_width_p(15), .core_id_p(2), .words_p(1)) u_rom4 (
        .clk_i(clk), .reset_i(reset), .addr_i(addr), .data_o(data_a[4]), .error_o(err_a[4]));

    int core_of [N] = '{0, 1, 2, 3, 2};
    int w_of    [N] = '{16, 16, 16, 16, 1};

    // Reference traces, built as the program a core would run.
    logic [72:0] trace [N][$];

    typedef struct packed {
        logic [14:0]    a;
        logic [N-1:0]   e;
        logic           ek;
        logic [N*73-1:0] d;
    } exp_t;

    exp_t sb_q [$];

    int errors = 0;
    int checks = 0;

    logic [N-1:0] em;
    logic         ek = 1'b0;

    function automatic logic [31:0] pat_ref(input int core, input int i);
        return (core << 24) | (32'hA5 << 16) | (i & 16'hFFFF);
    endfunction

    task automatic build_traces();
        for (int n = 0; n < N; n++) begin
            int base;
            base = core_of[n] * 512;
            trace[n].delete();
            for (int i = 0; i < w_of[n]; i++)
                trace[n].push_back({4'b0001, 4'b0, 1'b1, 32'(base + 4 * i), pat_ref(core_of[n], i)});
            for (int i = 0; i < w_of[n]; i++) begin
                trace[n].push_back({4'b0001, 4'b0, 1'b0, 32'(base + 4 * i), 32'h0});
                trace[n].push_back({4'b0010, 37'b0, pat_ref(core_of[n], i)});
            end
            trace[n].push_back({4'b0011, 69'b0});
        end
    endtask

    function automatic logic [72:0] ref_data(input int n, input int a);
        if (a < trace[n].size()) return trace[n][a];
        return {4'b0011, 69'b0};
    endfunction

    task automatic drive(input logic r, input logic [14:0] a);
        exp_t x;
        @(posedge clk);
        for (int n = 0; n < N; n++) begin
`ifdef TRACE_ROM_MONITOR_EN
            if (reset) em[n] = 1'b0;
            else if (ek && int'(addr) > 3 * w_of[n]) em[n] = 1'b1;
`else
            em[n] = 1'b0;
`endif
        end
`ifdef TRACE_ROM_MONITOR_EN
        if (reset) ek = 1'b1;
`else
        ek = 1'b1;
`endif
        #1;
        reset = r;
        addr  = a;
        x.a  = a;
        x.e  = em;
        x.ek = ek;
        for (int n = 0; n < N; n++) x.d[n*73 +: 73] = ref_data(n, int'(a));
        sb_q.push_back(x);
    endtask

    // Monitor: compare every presented entry against the scoreboard.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t x;
            x = sb_q.pop_front();
            for (int n = 0; n < N; n++) begin
                logic [72:0] got;
                got = data_a[n];
                checks++;
                if (got !== x.d[n*73 +: 73]) begin
                    errors++;
                    $display("FAIL data inst=%0d addr=%0d got=%h exp=%h", n, x.a, got, x.d[n*73 +: 73]);
                end
                if (got[72:69] == 4'b0001) begin
                    int base;
                    base = core_of[n] * 512;
                    checks++;
                    if (got[63:32] < 32'(base) || got[63:32] > 32'(base + 4 * (w_of[n] - 1))) begin
                        errors++;
                        $display("FAIL region inst=%0d addr=%0d got_addr=%h base=%h", n, x.a, got[63:32], base);
                    end
                end
                if (x.ek) begin
                    checks++;
                    if (err_a[n] !== x.e[n]) begin
                        errors++;
                        $display("FAIL error_o inst=%0d addr=%0d got=%b exp=%b", n, x.a, err_a[n], x.e[n]);
                    end
                end
            end
        end
    end

    initial begin
        em = '0;
        build_traces();

        drive(1'b1, 15'd0);
        drive(1'b1, 15'd0);
        drive(1'b0, 15'd3);
        drive(1'b0, 15'd22);
        drive(1'b0, 15'd23);
        drive(1'b0, 15'd47);
        drive(1'b0, 15'd48);
        drive(1'b0, 15'd48);
        drive(1'b0, 15'd49);
        drive(1'b0, 15'd0);
        drive(1'b0, 15'd1);
        drive(1'b1, 15'd2);
        drive(1'b0, 15'd3);
        drive(1'b1, 15'h7FFF);
        drive(1'b0, 15'd4);
        drive(1'b0, 15'h7FFF);
        drive(1'b0, 15'd5);
        drive(1'b1, 15'd6);
        drive(1'b0, 15'd3);

        for (int c = 0; c < 2; c++)
            for (int a = 0; a <= 48; a++) drive(1'b0, 15'(a));
        drive(1'b1, 15'd0);

        for (int it = 0; it < 400; it++) begin
            logic        r;
            logic [14:0] a;
            r = ($urandom_range(0, 19) == 0);
            a = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'($urandom_range(0, 60));
            drive(r, a);
        end

        for (int t = 0; t < 10 && sb_q.size() > 0; t++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
